arith_unit_seq: RTL and testbench

- Parametrised, registered successor to the combinational 32-bit arithmetic unit.
- Keeps the existing f codes 0100–0111 (add/sub/neg/inc) and adds carry-chained ops, an internal accumulator and a multi-cycle shift-add multiplier.
- Operands enter and results leave through valid/ready handshakes; results carry condition flags.
- Sits between operand registers and the writeback stage of the datapath.

---
 rtl/arith_unit_seq.sv | 157 +++++++++++++++
 tb/tb_arith_unit_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_seq.sv
// Registered arithmetic unit: add/sub/carry/accumulator ops in one cycle, shift-add MUL in WIDTH cycles.
// Valid/ready on both sides; a pending unconsumed result blocks new requests until out_ready.
module arith_unit_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] S_hi,
   output logic             c_out,
   output logic             z,
   output logic             n,
   output logic             v,
   output logic             err
);

   localparam logic [3:0] F_ADD = 4'b0100;
   localparam logic [3:0] F_SUB = 4'b0101;
   localparam logic [3:0] F_NEG = 4'b0110;
   localparam logic [3:0] F_INC = 4'b0111;
   localparam logic [3:0] F_ADC = 4'b1000;
   localparam logic [3:0] F_SBC = 4'b1001;
   localparam logic [3:0] F_ACC = 4'b1010;
   localparam logic [3:0] F_CLR = 4'b1011;
   localparam logic [3:0] F_MUL = 4'b1100;

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand, mplier, acc;
   logic [2*WIDTH-1:0] prod, prod_nxt;
   logic [WIDTH:0]     part;
   logic               cy;
   logic               accept, accept_mul, load_single, mul_last;

   logic [WIDTH-1:0]   op_a, op_b, r_s;
   logic               op_cin, use_sum, r_c, r_v, r_err, r_upd_cy;
   logic [WIDTH:0]     sum;

   assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
   assign accept      = in_valid && in_ready;
   assign accept_mul  = accept && (f == F_MUL);
   assign load_single = accept && (f != F_MUL);
   assign mul_last    = (state == MUL) && (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_mul) state_nxt = MUL;
         MUL:     if (mul_last)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One shift-add step: add multiplicand into the high half, then shift the whole product right.
   always_comb begin
      part = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (mplier[0]) part = part + {1'b0, mcand};
      prod_nxt = {part, prod[WIDTH-1:1]};
   end

   // All single-cycle ops share one adder; each code only chooses its operands and carry-in.
   always_comb begin
      op_a     = A;
      op_b     = B;
      op_cin   = 1'b0;
      use_sum  = 1'b1;
      r_err    = 1'b0;
      r_upd_cy = 1'b1;
      case (f)
         F_ADD: op_cin = 1'b0;
         F_SUB: begin op_b = ~B; op_cin = 1'b1; end
         F_NEG: begin op_a = ~A; op_b = '0; op_cin = 1'b1; end
         F_INC: begin op_b = '0; op_cin = 1'b1; end
         F_ADC: op_cin = cy;
         F_SBC: begin op_b = ~B; op_cin = cy; end
         F_ACC: begin op_a = acc; op_b = A; end
         F_CLR: begin use_sum = 1'b0; r_upd_cy = 1'b0; end
         default: begin use_sum = 1'b0; r_upd_cy = 1'b0; r_err = 1'b1; end
      endcase
      sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
      r_s = use_sum ? sum[WIDTH-1:0] : '0;
      r_c = use_sum & sum[WIDTH];
      r_v = use_sum & (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         S         <= '0;
         S_hi      <= '0;
         c_out     <= 1'b0;
         z         <= 1'b0;
         n         <= 1'b0;
         v         <= 1'b0;
         err       <= 1'b0;
         acc       <= '0;
         cy        <= 1'b0;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
      end else begin
         if (load_single) begin
            out_valid <= 1'b1;
            S         <= r_s;
            S_hi      <= '0;
            c_out     <= r_c;
            z         <= !r_err && (r_s == '0);
            n         <= r_s[WIDTH-1];
            v         <= r_v;
            err       <= r_err;
            if (r_upd_cy)        cy  <= r_c;
            if (f == F_ACC)      acc <= r_s;
            else if (f == F_CLR) acc <= '0;
         end else if (mul_last) begin
            out_valid <= 1'b1;
            S         <= prod_nxt[WIDTH-1:0];
            S_hi      <= prod_nxt[2*WIDTH-1:WIDTH];
            c_out     <= |prod_nxt[2*WIDTH-1:WIDTH];
            z         <= (prod_nxt[WIDTH-1:0] == '0);
            n         <= prod_nxt[WIDTH-1];
            v         <= 1'b0;
            err       <= 1'b0;
            cy        <= |prod_nxt[2*WIDTH-1:WIDTH];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept_mul) begin
            mcand  <= A;
            mplier <= B;
            prod   <= '0;
            cnt    <= '0;
         end else if (state == MUL) begin
            prod   <= prod_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq: directed scenarios plus randomized ops against a plain-arithmetic reference.
module tb_arith_unit_seq;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [3:0]    f = 4'h0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  S, S_hi;
   logic          c_out, z, n, v, err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic          m_cy;
   logic [W-1:0]  m_acc;

   arith_unit_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .f(f), .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .S_hi(S_hi), .c_out(c_out), .z(z), .n(n), .v(v), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   // Observed outputs packed as {out_valid, S, S_hi, c_out, z, n, v, err}.
   function automatic logic [69:0] obs();
      return {out_valid, S, S_hi, c_out, z, n, v, err};
   endfunction

   function automatic logic [69:0] ev(input logic [W-1:0] s, input logic [W-1:0] shi,
                                      input logic c, input logic zz, input logic nn,
                                      input logic vv, input logic ee);
      return {1'b1, s, shi, c, zz, nn, vv, ee};
   endfunction

   // Present one request from the next falling edge; returns 1ns after the accepting edge.
   task automatic issue(input logic [3:0] fc, input logic [W-1:0] a, input logic [W-1:0] b);
      int t = 0;
      @(negedge clk);
      f = fc; A = a; B = b; in_valid = 1'b1;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++; failures++;
         $display("FAIL issue_timeout in_ready stuck low for f=%h", fc);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int k);
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   // Reference: results from signed/unsigned integer arithmetic on 64-bit values.
   task automatic model(input logic [3:0] fc, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [69:0] e);
      longint unsigned ua, ub, ux, us;
      longint sa, sb, sx, sr, ci;
      logic [W-1:0] s, shi;
      logic c, vv, ee, upd;
      ua = a; ub = b; ux = m_acc;
      sa = longint'($signed(a)); sb = longint'($signed(b)); sx = longint'($signed(m_acc));
      ci = m_cy ? 1 : 0;
      s = '0; shi = '0; c = 1'b0; ee = 1'b0; sr = 0; upd = 1'b1; us = 0;
      case (fc)
         4'h4: begin us = ua + ub; s = us[31:0]; c = us[32]; sr = sa + sb; end
         4'h5: begin s = a - b; c = (ua >= ub); sr = sa - sb; end
         4'h6: begin s = 32'd0 - a; c = (a == 0); sr = -sa; end
         4'h7: begin us = ua + 1; s = us[31:0]; c = us[32]; sr = sa + 1; end
         4'h8: begin us = ua + ub + ci; s = us[31:0]; c = us[32]; sr = sa + sb + ci; end
         4'h9: begin s = a - b - 32'd1 + 32'(ci); c = (ua + ci > ub); sr = sa - sb - 1 + ci; end
         4'hA: begin us = ux + ua; s = us[31:0]; c = us[32]; sr = sx + sa; m_acc = s; end
         4'hB: begin m_acc = '0; upd = 1'b0; end
         4'hC: begin us = ua * ub; s = us[31:0]; shi = us[63:32]; c = |shi; end
         default: begin ee = 1'b1; upd = 1'b0; end
      endcase
      vv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      if (upd) m_cy = c;
      e = {1'b1, s, shi, c, (s == 0) && !ee, s[31], vv, ee};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 70'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs()); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_add_sub();
      logic [69:0] e;
      issue(4'h4, 32'd6, 32'd6);
      e = ev(32'd12, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL add_6_6 got=%h exp=%h", obs(), e); end
      issue(4'h5, 32'd6, 32'd6);
      e = ev(32'd0, '0, 1, 1, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL sub_6_6 got=%h exp=%h", obs(), e); end
   endtask

   task automatic test_neg_inc();
      logic [69:0] e;
      issue(4'h6, 32'd0, 32'd0);
      e = ev(32'd0, '0, 1, 1, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL neg_0 got=%h exp=%h", obs(), e); end
      issue(4'h7, 32'd0, 32'd0);
      e = ev(32'd1, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL inc_0 got=%h exp=%h", obs(), e); end
      issue(4'h6, 32'h8000_0000, 32'd0);
      e = ev(32'h8000_0000, '0, 0, 0, 1, 1, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL neg_min got=%h exp=%h", obs(), e); end
   endtask

   task automatic test_carry_chain();
      logic [69:0] e;
      issue(4'h4, 32'hFFFF_FFFF, 32'd1);
      e = ev(32'd0, '0, 1, 1, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL add_wrap got=%h exp=%h", obs(), e); end
      issue(4'h8, 32'd0, 32'd0);
      e = ev(32'd1, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL adc_cy1 got=%h exp=%h", obs(), e); end
      issue(4'h9, 32'd5, 32'd5);
      e = ev(32'hFFFF_FFFF, '0, 0, 0, 1, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL sbc_cy0 got=%h exp=%h", obs(), e); end
   endtask

   task automatic test_acc();
      logic [69:0] e;
      issue(4'hB, 32'd9, 32'd9);
      e = ev(32'd0, '0, 0, 1, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL clr got=%h exp=%h", obs(), e); end
      issue(4'hA, 32'd3, 32'd0);
      e = ev(32'd3, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL acc_3 got=%h exp=%h", obs(), e); end
      issue(4'hA, 32'd4, 32'd0);
      e = ev(32'd7, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL acc_7 got=%h exp=%h", obs(), e); end
      issue(4'hF, 32'd1, 32'd1);
      e = {1'b1, 32'd0, 32'd0, 5'b00001};
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL err_code got=%h exp=%h", obs(), e); end
      issue(4'hA, 32'd1, 32'd0);
      e = ev(32'd8, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL acc_after_err got=%h exp=%h", obs(), e); end
   endtask

   task automatic test_mul();
      logic [69:0] e;
      logic saw_ready;
      int k;
      issue(4'hC, 32'h0001_0000, 32'h0001_0000);
      saw_ready = 1'b0;
      k = 0;
      while (!out_valid && k < 100) begin
         if (in_ready) saw_ready = 1'b1;
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k !== 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", k); end
      checks++;
      if (saw_ready !== 1'b0) begin failures++; $display("FAIL mul_in_ready got=%b exp=0", saw_ready); end
      e = ev(32'd0, 32'd1, 1, 1, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL mul_result got=%h exp=%h", obs(), e); end
   endtask

   task automatic test_back_to_back();
      logic [69:0] e;
      int t0;
      issue(4'h4, 32'd1, 32'd2);
      t0 = cyc;
      e = ev(32'd3, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL b2b_add got=%h exp=%h", obs(), e); end
      issue(4'h7, 32'd9, 32'd0);
      e = ev(32'd10, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL b2b_inc got=%h exp=%h", obs(), e); end
      issue(4'h5, 32'd10, 32'd3);
      e = ev(32'd7, '0, 1, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL b2b_sub got=%h exp=%h", obs(), e); end
      checks++;
      if (cyc !== t0 + 2) begin failures++; $display("FAIL b2b_rate got=%0d exp=%0d", cyc - t0, 2); end
   endtask

   task automatic test_backpressure();
      logic [69:0] e, snap;
      logic held;
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      issue(4'h4, 32'd7, 32'd8);
      e = ev(32'd15, '0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL bp_result got=%h exp=%h", obs(), e); end
      snap = obs();
      @(negedge clk);
      in_valid = 1'b1; f = 4'h4; A = 32'd1; B = 32'd1;
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (in_ready !== 1'b0 || obs() !== snap) held = 1'b0;
      end
      checks++;
      if (held !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h exp=%h", obs(), snap); end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_mul();
      logic [69:0] e;
      logic seen;
      issue(4'hC, 32'd3, 32'd5);
      repeat (9) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs() !== 70'd0) begin failures++; $display("FAIL rst_mul_outputs got=%h exp=0", obs()); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mul_in_ready got=%b exp=1", in_ready); end
      @(negedge clk) rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL rst_mul_no_result got=%b exp=0", seen); end
      issue(4'h8, 32'd0, 32'd0);
      e = ev(32'd0, '0, 0, 1, 0, 0, 0);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL rst_cy_cleared got=%h exp=%h", obs(), e); end
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic test_random();
      logic [69:0] e;
      logic [3:0]  fc;
      logic [W-1:0] a, b;
      int k, r;
      test_reset();
      m_cy = 1'b0;
      m_acc = '0;
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 19);
         fc = (r < 16) ? 4'(4 + (r % 9)) : 4'($urandom_range(0, 15));
         a = rnd_operand();
         b = rnd_operand();
         model(fc, a, b, e);
         issue(fc, a, b);
         if (fc == 4'hC) wait_result(k);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL random_op%0d f=%h a=%h b=%h got=%h exp=%h", i, fc, a, b, obs(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_neg_inc();
      test_carry_chain();
      test_acc();
      test_mul();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_mul();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
